// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode with an 8-entry register file, load-use
// stall detection and a short ex -> mem -> wb control pipeline.
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle register
// write (wr_*) onto the decode read ports (write-through).
// Handshake: an instruction transfers when in_valid && in_ready are both high
// at a rising edge; in_ready depends on in_valid only through the load-use
// hazard check, and nothing downstream can stall the pipeline.
module decode_stage_p #(
  parameter int          DATA_W     = 16,
  parameter int unsigned IMM_SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ex_valid,
  output logic [2:0]        ex_alu_op,
  output logic              ex_imm_sel,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [2:0]        ex_dst,
  output logic              ex_dst_alu_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_st_data,
  output logic              wb_en,
  output logic [2:0]        wb_dst
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_LD  = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  logic [2:0]        w_op, w_r1, w_r2;
  logic [7:0]        w_imm8;
  logic              w_is_alu, w_is_ldi, w_is_ld, w_is_st;
  logic              w_uses_r1, w_uses_r2, w_hazard, w_accept;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm_ext;
  logic [2:0]        w_alu_op;

  logic [DATA_W-1:0] r_rf [8];
  logic              r_run;
  logic              r_ex_valid, r_ex_imm_sel, r_ex_dst_alu_sel;
  logic              r_ex_ld, r_ex_st, r_ex_wb;
  logic [2:0]        r_ex_alu_op, r_ex_dst;
  logic [DATA_W-1:0] r_ex_rd1, r_ex_rd2, r_ex_imm;
  logic              r_mem_read, r_mem_write, r_mem_wb;
  logic [2:0]        r_mem_dst;
  logic [DATA_W-1:0] r_mem_st_data;
  logic              r_wb_en;
  logic [2:0]        r_wb_dst;

  assign w_op   = instruction[15:13];
  assign w_r1   = instruction[12:10];
  assign w_r2   = instruction[9:7];
  assign w_imm8 = instruction[7:0];

  // Opcode classification and operand-use flags for the hazard check.
  always_comb begin
    w_is_alu  = (w_op >= OP_ADD) && (w_op <= OP_OR);
    w_is_ldi  = (w_op == OP_LDI);
    w_is_ld   = (w_op == OP_LD);
    w_is_st   = (w_op == OP_ST);
    w_uses_r2 = (w_op != OP_NOP) && !w_is_ldi;
    w_uses_r1 = w_is_alu || w_is_st;
    if (w_is_alu)                w_alu_op = w_op;
    else if (w_is_ld || w_is_st) w_alu_op = OP_ADD;
    else                         w_alu_op = 3'd0;
    if (IMM_SIGNED != 0) w_imm_ext = DATA_W'($signed(w_imm8));
    else                 w_imm_ext = DATA_W'(w_imm8);
  end

  // Register-file read ports, optionally forwarding the in-flight write.
  always_comb begin
    w_rd1 = r_rf[w_r1];
    w_rd2 = r_rf[w_r2];
`ifdef DECODE_BYPASS_EN
    if (wr_en && (wr_addr == w_r1)) w_rd1 = wr_data;
    if (wr_en && (wr_addr == w_r2)) w_rd2 = wr_data;
`endif
  end

  // Load-use stall: the load in ex has not produced its data yet.
  assign w_hazard = in_valid && r_ex_valid && r_ex_ld &&
                    ((w_uses_r2 && (r_ex_dst == w_r2)) ||
                     (w_uses_r1 && (r_ex_dst == w_r1)));
  assign in_ready = r_run && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Register file: single synchronous write port, all entries cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (wr_en) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  // Run flag holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Execute-stage register: decoded instruction or an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || !w_accept) begin
      r_ex_valid       <= 1'b0;
      r_ex_alu_op      <= 3'd0;
      r_ex_imm_sel     <= 1'b0;
      r_ex_rd1         <= '0;
      r_ex_rd2         <= '0;
      r_ex_imm         <= '0;
      r_ex_dst         <= 3'd0;
      r_ex_dst_alu_sel <= 1'b0;
      r_ex_ld          <= 1'b0;
      r_ex_st          <= 1'b0;
      r_ex_wb          <= 1'b0;
    end else begin
      r_ex_valid       <= 1'b1;
      r_ex_alu_op      <= w_alu_op;
      r_ex_imm_sel     <= w_is_ldi;
      r_ex_rd1         <= w_rd1;
      r_ex_rd2         <= w_rd2;
      r_ex_imm         <= w_imm_ext;
      r_ex_dst         <= w_r1;
      r_ex_dst_alu_sel <= !w_is_ld;
      r_ex_ld          <= w_is_ld;
      r_ex_st          <= w_is_st;
      r_ex_wb          <= w_is_alu || w_is_ldi || w_is_ld;
    end
  end

  // Memory-stage register: follows ex every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_st_data <= '0;
      r_mem_wb      <= 1'b0;
      r_mem_dst     <= 3'd0;
    end else begin
      r_mem_read    <= r_ex_ld;
      r_mem_write   <= r_ex_st;
      r_mem_st_data <= r_ex_st ? r_ex_rd1 : '0;
      r_mem_wb      <= r_ex_wb;
      r_mem_dst     <= r_ex_dst;
    end
  end

  // Writeback-stage register: follows mem every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_en  <= 1'b0;
      r_wb_dst <= 3'd0;
    end else begin
      r_wb_en  <= r_mem_wb;
      r_wb_dst <= r_mem_dst;
    end
  end

  assign ex_valid       = r_ex_valid;
  assign ex_alu_op      = r_ex_alu_op;
  assign ex_imm_sel     = r_ex_imm_sel;
  assign ex_rd1         = r_ex_rd1;
  assign ex_rd2         = r_ex_rd2;
  assign ex_imm         = r_ex_imm;
  assign ex_dst         = r_ex_dst;
  assign ex_dst_alu_sel = r_ex_dst_alu_sel;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_st_data    = r_mem_st_data;
  assign wb_en          = r_wb_en;
  assign wb_dst         = r_wb_dst;

endmodule

// File: tb/tb_decode_stage_p.sv
// Testbench for decode_stage_p: directed scenarios followed by random traffic,
// checked against a transaction-level reference model of decode and pipeline.
module tb_decode_stage_p;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, wr_en;
  logic [15:0] instruction, wr_data;
  logic [2:0]  wr_addr;

  logic        in_ready, ex_valid, ex_imm_sel, ex_dst_alu_sel;
  logic [2:0]  ex_alu_op, ex_dst, wb_dst;
  logic [15:0] ex_rd1, ex_rd2, ex_imm, mem_st_data;
  logic        mem_read, mem_write, wb_en;

  logic        z_in_ready, z_ex_valid, z_ex_imm_sel, z_ex_dst_alu_sel;
  logic [2:0]  z_ex_alu_op, z_ex_dst, z_wb_dst;
  logic [15:0] z_ex_rd1, z_ex_rd2, z_ex_imm, z_mem_st_data;
  logic        z_mem_read, z_mem_write, z_wb_en;

  decode_stage_p #(.DATA_W(16), .IMM_SIGNED(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_imm_sel(ex_imm_sel),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_dst(ex_dst),
    .ex_dst_alu_sel(ex_dst_alu_sel), .mem_read(mem_read), .mem_write(mem_write),
    .mem_st_data(mem_st_data), .wb_en(wb_en), .wb_dst(wb_dst));

  decode_stage_p #(.DATA_W(16), .IMM_SIGNED(0)) u_dut_z (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(z_in_ready),
    .instruction(instruction), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ex_valid(z_ex_valid), .ex_alu_op(z_ex_alu_op), .ex_imm_sel(z_ex_imm_sel),
    .ex_rd1(z_ex_rd1), .ex_rd2(z_ex_rd2), .ex_imm(z_ex_imm), .ex_dst(z_ex_dst),
    .ex_dst_alu_sel(z_ex_dst_alu_sel), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .mem_st_data(z_mem_st_data), .wb_en(z_wb_en), .wb_dst(z_wb_dst));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit last_rdy;
  int rd_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_rf [8];
  bit          m_run;
  bit          mx_v, mx_isel, mx_dsel, mx_ld, mx_st, mx_wb;
  logic [2:0]  mx_op, mx_dst;
  logic [15:0] mx_rd1, mx_rd2, mx_imm, mx_immz;
  bit          mm_rd, mm_wr, mm_wb;
  logic [2:0]  mm_dst;
  logic [15:0] mm_st;
  bit          mw_en;
  logic [2:0]  mw_dst;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_run = 0;
    mx_v = 0; mx_isel = 0; mx_dsel = 0; mx_ld = 0; mx_st = 0; mx_wb = 0;
    mx_op = 0; mx_dst = 0; mx_rd1 = 0; mx_rd2 = 0; mx_imm = 0; mx_immz = 0;
    mm_rd = 0; mm_wr = 0; mm_wb = 0; mm_dst = 0; mm_st = 0;
    mw_en = 0; mw_dst = 0;
  endtask

  function automatic bit model_ready(input bit v, input logic [15:0] ins);
    int op, r1, r2;
    bit reads_r1, reads_r2;
    op = int'(ins[15:13]); r1 = int'(ins[12:10]); r2 = int'(ins[9:7]);
    if (!m_run) return 1'b0;
    if (!(v && mx_v && mx_ld)) return 1'b1;
    reads_r2 = !(op == 0 || op == 5);
    reads_r1 = (op >= 1 && op <= 4) || op == 7;
    return !((reads_r2 && int'(mx_dst) == r2) || (reads_r1 && int'(mx_dst) == r1));
  endfunction

  function automatic logic [15:0] model_read(input int a, input bit we,
                                              input logic [2:0] wa, input logic [15:0] wd);
`ifdef DECODE_BYPASS_EN
    if (we && int'(wa) == a) return wd;
`endif
    return m_rf[a];
  endfunction

  task automatic check_all();
    chk("ex_valid", ex_valid, mx_v);
    chk("ex_alu_op", ex_alu_op, mx_op);
    chk("ex_imm_sel", ex_imm_sel, mx_isel);
    chk("ex_rd1", ex_rd1, mx_rd1);
    chk("ex_rd2", ex_rd2, mx_rd2);
    chk("ex_imm", ex_imm, mx_imm);
    chk("ex_imm_zext", z_ex_imm, mx_immz);
    chk("ex_dst", ex_dst, mx_dst);
    chk("ex_dst_alu_sel", ex_dst_alu_sel, mx_dsel);
    chk("mem_read", mem_read, mm_rd);
    chk("mem_write", mem_write, mm_wr);
    chk("mem_st_data", mem_st_data, mm_st);
    chk("wb_en", wb_en, mw_en);
    chk("wb_dst", wb_dst, mw_dst);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives one cycle and checks both sides.
  task automatic step(input bit v, input logic [15:0] ins, input bit we,
                      input logic [2:0] wa, input logic [15:0] wd);
    bit acc, n_v, n_isel, n_dsel, n_ld, n_st, n_wb;
    logic [2:0] n_op, n_dst;
    logic [15:0] n_rd1, n_rd2, n_imm, n_immz;
    int op, imm8;
    in_valid = v; instruction = ins; wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    last_rdy = model_ready(v, ins);
    chk("in_ready", in_ready, last_rdy);
    acc = v && last_rdy;
    op = int'(ins[15:13]); imm8 = int'(ins[7:0]);
    n_v = 0; n_isel = 0; n_dsel = 0; n_ld = 0; n_st = 0; n_wb = 0;
    n_op = 0; n_dst = 0; n_rd1 = 0; n_rd2 = 0; n_imm = 0; n_immz = 0;
    if (acc) begin
      n_v = 1; n_dst = ins[12:10];
      n_rd1 = model_read(int'(ins[12:10]), we, wa, wd);
      n_rd2 = model_read(int'(ins[9:7]), we, wa, wd);
      n_imm = (imm8 >= 128) ? 16'(imm8 + 16'hFF00) : 16'(imm8);
      n_immz = 16'(imm8);
      n_dsel = (op != 6);
      case (op)
        1, 2, 3, 4: begin n_op = 3'(op); n_wb = 1; end
        5: begin n_isel = 1; n_wb = 1; end
        6: begin n_op = 3'd1; n_ld = 1; n_wb = 1; end
        7: begin n_op = 3'd1; n_st = 1; end
        default: ;
      endcase
    end
    @(posedge clk);
    mw_en = mm_wb; mw_dst = mm_dst;
    mm_rd = mx_ld; mm_wr = mx_st; mm_st = mx_st ? mx_rd1 : 16'h0;
    mm_wb = mx_wb; mm_dst = mx_dst;
    mx_v = n_v; mx_isel = n_isel; mx_dsel = n_dsel; mx_ld = n_ld; mx_st = n_st;
    mx_wb = n_wb; mx_op = n_op; mx_dst = n_dst; mx_rd1 = n_rd1; mx_rd2 = n_rd2;
    mx_imm = n_imm; mx_immz = n_immz;
    if (we) m_rf[wa] = wd;
    m_run = 1;
    #1;
    check_all();
    if (mem_read === 1'b1) rd_cnt++;
  endtask

  function automatic logic [15:0] rr(input int op, input int r1, input int r2);
    return {3'(op), 3'(r1), 3'(r2), 7'd0};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    step(0, 16'h0, 1, 3'(a), d);
  endtask

  task automatic idle();
    step(0, 16'h0, 0, 3'd0, 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 0; in_valid = 0; instruction = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_cnt = 0; last_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_in_ready", in_ready, 0);
    reset = 1;

    // ADD r3,r4 with r3=5, r4=3
    wr(3, 16'h0005);
    wr(4, 16'h0003);
    step(1, rr(1, 3, 4), 0, 0, 0);
    chk("add_rd1", ex_rd1, 16'h0005);
    chk("add_rd2", ex_rd2, 16'h0003);
    chk("add_alu_op", ex_alu_op, 3'b001);
    idle(); idle();
    chk("add_wb_en", wb_en, 1);
    chk("add_wb_dst", wb_dst, 3);

    // LDI r2, 0xF0: signed and zero-extended immediate
    step(1, {3'd5, 3'd2, 2'b00, 8'hF0}, 0, 0, 0);
    chk("ldi_imm_s", ex_imm, 16'hFFF0);
    chk("ldi_imm_z", z_ex_imm, 16'h00F0);
    chk("ldi_imm_sel", ex_imm_sel, 1);

    // LD r1,[r2] then ADD r1,r5: one stall, one bubble, single mem_read
    wr(2, 16'h0042);
    rd_cnt = 0;
    step(1, rr(6, 1, 2), 0, 0, 0);
    step(1, rr(1, 1, 5), 0, 0, 0);
    chk("lu_stall_ready", last_rdy, 0);
    chk("lu_bubble", ex_valid, 0);
    step(1, rr(1, 1, 5), 0, 0, 0);
    chk("lu_accept_ready", in_ready, 1);
    chk("lu_accept_ex", ex_valid, 1);
    idle(); idle();
    chk("lu_mem_read_once", rd_cnt, 1);

    // ST r6,[r7] with r6=0x1234
    wr(6, 16'h1234);
    step(1, rr(7, 6, 7), 0, 0, 0);
    idle();
    chk("st_mem_write", mem_write, 1);
    chk("st_data", mem_st_data, 16'h1234);
    idle();
    chk("st_wb_en", wb_en, 0);

    // Same-cycle write to r2 while decoding ADD r2,r0
    step(1, rr(1, 2, 0), 1, 3'd2, 16'hAAAA);
`ifdef DECODE_BYPASS_EN
    chk("bypass_rd1", ex_rd1, 16'hAAAA);
`else
    chk("bypass_rd1", ex_rd1, 16'h0042);
`endif
    idle(); idle();

    // Reset asserted during a load-use stall
    step(1, rr(6, 1, 2), 0, 0, 0);
    in_valid = 1; instruction = rr(1, 1, 5);
    @(negedge clk);
    chk("rst_stall_ready", in_ready, 0);
    #1 reset = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_in_ready", in_ready, 0);
    in_valid = 0; instruction = 0;
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("rst_no_wb", wb_en, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register/datapath width (allowed 8..32).
REQ-002 The block SHALL have parameter IMM_SIGNED, default 1, meaning 1 = sign-extend instruction[7:0] to DATA_W, 0 = zero-extend.
REQ-003 The block SHALL have port clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  in  1  instruction present.
REQ-006 The block SHALL have port in_ready  out  1  instruction accepted this cycle.
REQ-007 The block SHALL have port instruction  in  16  opcode [15:13], r1 [12:10], r2 [9:7], imm [7:0].
REQ-008 The block SHALL have port wr_en, wr_addr, wr_data  in  1/3/DATA_W  register-file write from writeback.
REQ-009 The block SHALL have port ex_valid, ex_alu_op, ex_imm_sel  out  1/3/1  execute-stage control.
REQ-010 The block SHALL have port ex_rd1, ex_rd2, ex_imm  out  DATA_W each  execute-stage operands.
REQ-011 The block SHALL have port ex_dst, ex_dst_alu_sel  out  3/1  destination register; 1 = ALU result, 0 = memory result.
REQ-012 The block SHALL have port mem_read, mem_write, mem_st_data  out  1/1/DATA_W  memory-stage controls, one cycle after ex_*.
REQ-013 The block SHALL have port wb_en, wb_dst  out  1/3  writeback controls, one cycle after mem_*.

Function
REQ-014 Decode SHALL be: 000 NOP; 001 ADD, 010 SUB, 011 AND, 100 OR (r1 <= r1 op r2); 101 LDI (r1 <= imm); 110 LD (r1 <= mem[r2]); 111 ST (mem[r2] <= r1).
REQ-015 The register file SHALL be 8 x DATA_W, with two combinational read ports (r1, r2), one synchronous write port, and register 0 writable.
REQ-016 ex_alu_op SHALL equal the opcode for ALU ops, 001 (ADD) for LD/ST address pass-through, and 000 otherwise; ex_imm_sel SHALL be 1 only for LDI.
REQ-017 Control SHALL be: wb for ALU ops, LDI and LD; mem_read for LD only; mem_write for ST only; ex_dst_alu_sel = 0 for LD only.
REQ-018 Accepting an instruction (in_valid && in_ready) SHALL load ex_* on the next rising edge (latency 1).
REQ-019 ex_* SHALL advance to mem_* on every edge, and mem_* to wb_* on every edge; there is no downstream backpressure.
REQ-020 mem_st_data SHALL carry the registered ex_rd1 of the ST.
REQ-021 A load-use hazard exists when ex_valid && ex is LD && in_valid && (ex_dst == r2 for any non-NOP/LDI op, or ex_dst == r1 for an ALU op or ST).
REQ-022 On a load-use hazard, in_ready SHALL be 0 and ex_* SHALL load a bubble (ex_valid = 0, all controls 0) for exactly one cycle.
REQ-023 With no hazard, in_ready SHALL be 1; when in_valid = 0, ex_* SHALL load a bubble.
REQ-024 Bubbles SHALL propagate with mem_read = mem_write = wb_en = 0.
REQ-025 ex_imm SHALL be DATA_W bits, extended per IMM_SIGNED; operand widths SHALL never truncate.

Reset
REQ-026 While reset = 0, all register-file entries and every ex_/mem_/wb_ output register SHALL be 0, and in_ready SHALL be 0.
REQ-027 Deassertion SHALL take effect at the next rising edge; a reset during a stall SHALL discard the stalled instruction.

Configuration
REQ-028 With macro DECODE_BYPASS_EN defined, a read whose address equals wr_addr while wr_en = 1 SHALL return wr_data in the same cycle (write-through).
REQ-029 Without DECODE_BYPASS_EN, such a read SHALL return the old register value; software or the hazard unit covers the gap.

Verification
REQ-030 The bench SHALL cover: reset; write r3 = 0x0005 and r4 = 0x0003; ADD r3,r4 -> next cycle ex_rd1 = 5, ex_rd2 = 3, ex_alu_op = 001, and 2 cycles later wb_en = 1 with wb_dst = 3.
REQ-031 The bench SHALL cover: LDI r2, imm = 0xF0 with IMM_SIGNED = 1 -> ex_imm = 0xFFF0 and ex_imm_sel = 1; with IMM_SIGNED = 0 -> ex_imm = 0x00F0.
REQ-032 The bench SHALL cover: LD r1,[r2] followed by ADD r1,r5 -> in_ready = 0 for one cycle, one bubble in ex, ADD accepted on the following cycle, and mem_read = 1 exactly once.
REQ-033 The bench SHALL cover: ST r6,[r7] with r6 = 0x1234 -> mem_write = 1, mem_st_data = 0x1234, and wb_en = 0.
REQ-034 The bench SHALL cover: wr_en = 1, wr_addr = 2, wr_data = 0xAAAA in the same cycle as decoding ADD r2,r0 -> ex_rd1 = 0xAAAA with DECODE_BYPASS_EN, and the old value without it.
REQ-035 The bench SHALL cover: asserting reset while stalled -> all outputs 0 immediately, and no wb_en after release.
